// File: rtl/lwe_pkg.sv
// Shared LWE constants and derived-size helpers for the encrypt/decrypt pair.
package lwe_pkg;

    localparam int DEF_PLAINTEXT_MODULUS  = 64;
    localparam int DEF_PLAINTEXT_WIDTH    = 8;
    localparam int DEF_CIPHERTEXT_MODULUS = 1024;
    localparam int DEF_CIPHERTEXT_WIDTH   = 16;
    localparam int DEF_DIMENSION          = 3;
    localparam int DEF_BIG_N              = 30;
    localparam int DEF_PARALLEL           = 2;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_ACCUM,
        ST_ENCODE,
        ST_OUTPUT
    } enc_state_e;

    function automatic int lwe_clog2(input int v);
        int r;
        r = 0;
        for (int i = 0; i < 31; i++)
            if ((1 << i) < v) r = i + 1;
        return r;
    endfunction

    function automatic bit lwe_is_pow2(input int v);
        return (v > 0) && ((v & (v - 1)) == 0);
    endfunction

    function automatic int lwe_chunks(input int dimension, input int parallel);
        return (dimension + 1) / parallel;
    endfunction

    function automatic int lwe_qbits(input int q);
        return lwe_clog2(q);
    endfunction

    function automatic int lwe_delta(input int q, input int p);
        return q / p;
    endfunction

endpackage

// File: rtl/mod_add_vec.sv
// Lane-parallel adder modulo 2**QBITS; disabled lanes pass operand a through.
module mod_add_vec #(
    parameter int LANES = 2,
    parameter int W     = 16,
    parameter int QBITS = 10
) (
    input  logic [LANES-1:0][W-1:0] a,
    input  logic [LANES-1:0][W-1:0] b,
    input  logic [LANES-1:0]        en,
    output logic [LANES-1:0][W-1:0] sum
);

    for (genvar i = 0; i < LANES; i++) begin : g_lane
        logic [QBITS-1:0] s;

        // Truncating both operands to QBITS is the whole modular reduction.
        assign s      = a[i][QBITS-1:0] + b[i][QBITS-1:0];
        assign sum[i] = en[i] ? W'(s) : a[i];

        if (W > QBITS) begin : g_hi
            logic unused_hi;
            assign unused_hi = ^b[i][W-1:QBITS];
        end
    end

endmodule

// File: rtl/encrypt.sv
// Streaming LWE encryption: accumulates selected public-key samples chunk by
// chunk, adds m*DELTA to entry 0, then streams the ciphertext out per chunk.
module encrypt
    import lwe_pkg::*;
#(
    parameter int PLAINTEXT_MODULUS  = DEF_PLAINTEXT_MODULUS,
    parameter int PLAINTEXT_WIDTH    = DEF_PLAINTEXT_WIDTH,
    parameter int CIPHERTEXT_MODULUS = DEF_CIPHERTEXT_MODULUS,
    parameter int CIPHERTEXT_WIDTH   = DEF_CIPHERTEXT_WIDTH,
    parameter int DIMENSION          = DEF_DIMENSION,
    parameter int BIG_N              = DEF_BIG_N,
    parameter int PARALLEL           = DEF_PARALLEL
) (
    input  logic                                 clk,
    input  logic                                 rst_n,
    input  logic                                 start,
    input  logic [PLAINTEXT_WIDTH-1:0]           plaintext,
    input  logic                                 in_valid,
    output logic                                 in_ready,
    input  logic                                 subset_bit,
    input  logic [PARALLEL*CIPHERTEXT_WIDTH-1:0] publickey_entry,
    output logic                                 out_valid,
    input  logic                                 out_ready,
    output logic [PARALLEL*CIPHERTEXT_WIDTH-1:0] ciphertext_entry,
    output logic [((PARALLEL < DIMENSION+1) ? $clog2((DIMENSION+1)/PARALLEL) : 1)-1:0] row,
    output logic                                 busy,
    output logic                                 done
);

    localparam int W      = CIPHERTEXT_WIDTH;
    localparam int CHUNKS = lwe_chunks(DIMENSION, PARALLEL);
    localparam int QBITS  = lwe_qbits(CIPHERTEXT_MODULUS);
    localparam int PBITS  = lwe_qbits(PLAINTEXT_MODULUS);
    localparam int RW     = (CHUNKS > 1) ? $clog2(CHUNKS) : 1;
    localparam int NW     = (BIG_N > 1) ? $clog2(BIG_N) : 1;
    localparam logic [W-1:0] DELTA_W = W'(lwe_delta(CIPHERTEXT_MODULUS, PLAINTEXT_MODULUS));

    if (!lwe_is_pow2(PLAINTEXT_MODULUS)) begin : g_chk_p
        $error("encrypt: PLAINTEXT_MODULUS must be a power of two");
    end
    if (!lwe_is_pow2(CIPHERTEXT_MODULUS)) begin : g_chk_q
        $error("encrypt: CIPHERTEXT_MODULUS must be a power of two");
    end
    if ((DIMENSION + 1) % PARALLEL != 0) begin : g_chk_par
        $error("encrypt: PARALLEL must divide DIMENSION+1");
    end
    if (CIPHERTEXT_WIDTH < QBITS) begin : g_chk_w
        $error("encrypt: CIPHERTEXT_WIDTH narrower than log2(q)");
    end
    if (PLAINTEXT_WIDTH > PBITS) begin : g_pt_hi
        logic unused_pt;
        assign unused_pt = ^plaintext[PLAINTEXT_WIDTH-1:PBITS];
    end

    enc_state_e state, state_nxt;

    logic [CHUNKS-1:0][PARALLEL-1:0][W-1:0] acc;
    logic [PBITS-1:0]                       m_q;
    logic [NW-1:0]                          smp_cnt;
    logic [RW-1:0]                          chk_cnt;
    logic                                   sel_q;

    logic [PARALLEL-1:0][W-1:0] add_a, add_b, add_sum;
    logic [PARALLEL-1:0]        add_en;
    logic [W-1:0]               enc_val;
    logic beat, eff_sel, last_chunk, last_beat, out_fire, last_row;

    assign in_ready   = (state == ST_ACCUM);
    assign out_valid  = (state == ST_OUTPUT);
    assign busy       = (state != ST_IDLE);
    assign beat       = in_valid && in_ready;
    assign last_chunk = (chk_cnt == RW'(CHUNKS - 1));
    assign last_beat  = beat && last_chunk && (smp_cnt == NW'(BIG_N - 1));
    assign out_fire   = out_valid && out_ready;
    assign last_row   = (row == RW'(CHUNKS - 1));
    // The select bit travels with chunk 0; later chunks reuse the registered copy.
    assign eff_sel    = (chk_cnt == '0) ? subset_bit : sel_q;
    assign enc_val    = W'(m_q) * DELTA_W;

    assign ciphertext_entry = out_valid ? acc[row] : '0;

    always_comb begin
        add_a  = acc[chk_cnt];
        add_b  = publickey_entry;
        add_en = {PARALLEL{eff_sel}};
        if (state == ST_ENCODE) begin
            add_a    = acc[0];
            add_b    = '0;
            add_b[0] = enc_val;
            add_en   = '0;
            add_en[0] = 1'b1;
        end
    end

    mod_add_vec #(
        .LANES (PARALLEL),
        .W     (W),
        .QBITS (QBITS)
    ) u_add (
        .a   (add_a),
        .b   (add_b),
        .en  (add_en),
        .sum (add_sum)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= ST_IDLE;
        else        state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE:   if (start) state_nxt = ST_ACCUM;
            ST_ACCUM:  if (last_beat) state_nxt = ST_ENCODE;
            ST_ENCODE: state_nxt = ST_OUTPUT;
            ST_OUTPUT: if (out_fire && last_row) state_nxt = ST_IDLE;
            default:   state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            acc     <= '0;
            m_q     <= '0;
            smp_cnt <= '0;
            chk_cnt <= '0;
            sel_q   <= 1'b0;
            row     <= '0;
            done    <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                ST_IDLE: if (start) begin
                    m_q     <= plaintext[PBITS-1:0];
                    acc     <= '0;
                    smp_cnt <= '0;
                    chk_cnt <= '0;
                    sel_q   <= 1'b0;
                    row     <= '0;
                end
                ST_ACCUM: if (beat) begin
                    acc[chk_cnt] <= add_sum;
                    if (chk_cnt == '0) sel_q <= subset_bit;
                    if (last_chunk) begin
                        chk_cnt <= '0;
                        smp_cnt <= smp_cnt + 1'b1;
                    end else begin
                        chk_cnt <= chk_cnt + 1'b1;
                    end
                end
                ST_ENCODE: begin
                    acc[0] <= add_sum;
                    row    <= '0;
                end
                ST_OUTPUT: if (out_fire) begin
                    row  <= last_row ? '0 : row + 1'b1;
                    done <= last_row;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_encrypt.sv
// Directed vector bench for encrypt at default parameters.
module tb_encrypt;

    localparam int W  = 16;
    localparam int P  = 2;
    localparam int CH = 2;
    localparam int BN = 30;

    typedef struct {
        string            name;
        logic [BN-1:0]    sel;
        logic [3:0][15:0] ent;
        logic [7:0]       m;
        bit               gaps;
        bit               toggle;
        bit               glitch;
        int               stall;
        logic [3:0][15:0] exp;
    } vec_t;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          start = 1'b0;
    logic [7:0]    plaintext = '0;
    logic          in_valid = 1'b0;
    logic          subset_bit = 1'b0;
    logic [P*W-1:0] publickey_entry = '0;
    logic          out_ready = 1'b0;
    logic          in_ready, out_valid, busy, done;
    logic [P*W-1:0] ciphertext_entry;
    logic [0:0]    row;

    int total = 0;
    int bad   = 0;
    vec_t vecs[7];

    encrypt dut (
        .clk              (clk),
        .rst_n            (rst_n),
        .start            (start),
        .plaintext        (plaintext),
        .in_valid         (in_valid),
        .in_ready         (in_ready),
        .subset_bit       (subset_bit),
        .publickey_entry  (publickey_entry),
        .out_valid        (out_valid),
        .out_ready        (out_ready),
        .ciphertext_entry (ciphertext_entry),
        .row              (row),
        .busy             (busy),
        .done             (done)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [63:0] got, input logic [63:0] want);
        total++;
        if (got !== want) begin
            bad++;
            $display("FAIL %s: got %0d want %0d", name, got, want);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic run_vec(input vec_t v);
        logic [CH-1:0][P*W-1:0] got;
        logic [P*W-1:0]         hold;
        plaintext = v.m;
        start = 1'b1;
        tick;
        start = 1'b0;
        plaintext = 8'hFF;
        check($sformatf("%s/in_ready_lat", v.name), in_ready, 1);
        for (int n = 0; n < BN; n++) begin
            for (int k = 0; k < CH; k++) begin
                if (v.gaps) begin
                    in_valid = 1'b0;
                    repeat ($urandom_range(0, 2)) tick;
                end
                in_valid = 1'b1;
                subset_bit = (k != 0 && v.toggle) ? ~v.sel[n] : v.sel[n];
                publickey_entry = v.sel[n] ? {v.ent[2*k+1], v.ent[2*k]} : $urandom;
                if (v.glitch && n == 10 && k == 0) begin
                    start = 1'b1;
                    plaintext = 8'd7;
                end
                check($sformatf("%s/in_ready n%0d k%0d", v.name, n, k), in_ready, 1);
                tick;
                start = 1'b0;
            end
        end
        in_valid = 1'b0;
        subset_bit = 1'b0;
        check($sformatf("%s/encode_out_valid", v.name), out_valid, 0);
        check($sformatf("%s/encode_in_ready", v.name), in_ready, 0);
        tick;
        check($sformatf("%s/first_out_valid", v.name), out_valid, 1);
        check($sformatf("%s/first_row", v.name), row, 0);
        if (v.stall > 0) begin
            out_ready = 1'b0;
            hold = ciphertext_entry;
            repeat (v.stall) begin
                tick;
                check($sformatf("%s/stall_valid", v.name), out_valid, 1);
                check($sformatf("%s/stall_row", v.name), row, 0);
                check($sformatf("%s/stall_data", v.name), ciphertext_entry, hold);
            end
        end
        out_ready = 1'b1;
        for (int c = 0; c < CH; c++) begin
            check($sformatf("%s/row%0d_valid", v.name, c), out_valid, 1);
            check($sformatf("%s/row%0d_idx", v.name, c), row, c);
            got[c] = ciphertext_entry;
            tick;
        end
        out_ready = 1'b0;
        check($sformatf("%s/done_pulse", v.name), done, 1);
        check($sformatf("%s/post_valid", v.name), out_valid, 0);
        check($sformatf("%s/post_busy", v.name), busy, 0);
        tick;
        check($sformatf("%s/done_clear", v.name), done, 0);
        for (int c = 0; c < CH; c++)
            for (int j = 0; j < P; j++)
                check($sformatf("%s/ct[%0d]", v.name, c*P+j), got[c][j*W +: W], v.exp[c*P+j]);
    endtask

    task automatic check_reset_vals(input string tag);
        check({tag, "/in_ready"}, in_ready, 0);
        check({tag, "/out_valid"}, out_valid, 0);
        check({tag, "/ct"}, ciphertext_entry, 0);
        check({tag, "/row"}, row, 0);
        check({tag, "/busy"}, busy, 0);
        check({tag, "/done"}, done, 0);
    endtask

    initial begin
        vecs[0] = '{name:"none_m5", sel:30'h0, ent:'0, m:8'd5, gaps:0, toggle:0, glitch:0,
                    stall:0, exp:{16'd0, 16'd0, 16'd0, 16'd80}};
        vecs[1] = '{name:"s0_only", sel:30'h1, ent:{16'd8, 16'd4, 16'd3, 16'd9}, m:8'd0,
                    gaps:0, toggle:0, glitch:0, stall:0, exp:{16'd8, 16'd4, 16'd3, 16'd9}};
        vecs[2] = '{name:"wrap", sel:30'h3, ent:{16'd1, 16'd512, 16'd1023, 16'd1000}, m:8'd63,
                    gaps:0, toggle:0, glitch:0, stall:0, exp:{16'd2, 16'd0, 16'd1022, 16'd960}};
        vecs[3] = '{name:"stall5", sel:30'h1, ent:{16'd8, 16'd4, 16'd3, 16'd9}, m:8'd0,
                    gaps:0, toggle:0, glitch:0, stall:5, exp:{16'd8, 16'd4, 16'd3, 16'd9}};
        vecs[4] = '{name:"s2_toggle", sel:30'h4, ent:{16'd1, 16'd1, 16'd1, 16'd1}, m:8'd0,
                    gaps:1, toggle:1, glitch:1, stall:0, exp:{16'd1, 16'd1, 16'd1, 16'd1}};
        vecs[5] = '{name:"all_sel", sel:30'h3FFFFFFF, ent:{16'd4, 16'd3, 16'd2, 16'd1}, m:8'd1,
                    gaps:0, toggle:0, glitch:0, stall:0, exp:{16'd120, 16'd90, 16'd60, 16'd46}};
        vecs[6] = '{name:"trunc", sel:30'h20000000, ent:{16'h8005, 16'hFFFF, 16'h0400, 16'hFC01},
                    m:8'hC2, gaps:0, toggle:0, glitch:0, stall:0,
                    exp:{16'd5, 16'd1023, 16'd0, 16'd33}};

        repeat (2) @(posedge clk);
        #1;
        check_reset_vals("reset");
        rst_n = 1'b1;
        tick;

        for (int i = 0; i < 7; i++) run_vec(vecs[i]);

        // Abort mid-accumulation; the rerun must carry no stale sums.
        plaintext = 8'd3;
        start = 1'b1;
        tick;
        start = 1'b0;
        in_valid = 1'b1;
        subset_bit = 1'b1;
        publickey_entry = {16'd100, 16'd200};
        repeat (20) tick;
        check("abort/busy_before", busy, 1);
        #2 rst_n = 1'b0;
        #1;
        check_reset_vals("abort");
        tick;
        check_reset_vals("abort_hold");
        in_valid = 1'b0;
        subset_bit = 1'b0;
        rst_n = 1'b1;
        tick;
        check("abort/idle_out_valid", out_valid, 0);
        run_vec(vecs[1]);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/encrypt.md
# encrypt

Streaming LWE encryption engine, the transmit-side counterpart of `decrypt`. It accumulates a random subset of the `BIG_N` public-key samples, `PARALLEL` entries per beat, and adds the scaled plaintext to entry 0. It then streams the `DIMENSION+1`-entry ciphertext out in the same chunk order that `decrypt` consumes: chunk `r` carries entries `r*PARALLEL .. r*PARALLEL+PARALLEL-1`.

## Interface
Parameters:
- `PLAINTEXT_MODULUS`, 64, plaintext modulus p; power of two.
- `PLAINTEXT_WIDTH`, 8, plaintext port width.
- `CIPHERTEXT_MODULUS`, 1024, ciphertext modulus q; power of two, q > p.
- `CIPHERTEXT_WIDTH`, 16, entry width; must be at least log2(q).
- `DIMENSION`, 3, LWE dimension; each sample and the ciphertext have `DIMENSION+1` entries.
- `BIG_N`, 30, number of public-key samples.
- `PARALLEL`, 2, entries per beat; must divide `DIMENSION+1`.

Ports:
- `clk`, in, 1, single clock.
- `rst_n`, in, 1, reset; asynchronous, active-low.
- `start`, in, 1, begins an encryption; honoured only in IDLE.
- `plaintext`, in, `PLAINTEXT_WIDTH`, message m; sampled on an accepted `start`.
- `in_valid`, in, 1, a public-key beat is present.
- `in_ready`, out, 1, the block accepts beats.
- `subset_bit`, in, 1, selects the current sample; sampled on chunk 0 of each sample only.
- `publickey_entry`, in, `PARALLEL*CIPHERTEXT_WIDTH`, packed entries; entry j is at bits `[j*W +: W]`.
- `out_valid`, out, 1, a ciphertext chunk is present.
- `out_ready`, in, 1, the consumer accepts the chunk.
- `ciphertext_entry`, out, `PARALLEL*CIPHERTEXT_WIDTH`, packed output chunk.
- `row`, out, `$clog2(CHUNKS)` bits (minimum 1), index of the current output chunk.
- `busy`, out, 1, high whenever the state is not IDLE.
- `done`, out, 1, one-cycle pulse after the last chunk is accepted.

## Operation
- Derived constants: `CHUNKS = (DIMENSION+1)/PARALLEL`, `QBITS = log2(q)`, `DELTA = q/p` (16 at defaults).
- State machine:
  - IDLE, then on `start`: latch `m mod p` (low log2(p) bits), clear all accumulators, clear the sample and chunk counters, go to ACCUM.
  - ACCUM: `in_ready = 1`. Each beat (`in_valid && in_ready`) addresses sample n, chunk k.
  - On k = 0 the block registers `subset_bit`. The effective select is the live bit when k = 0 and the registered bit when k > 0.
  - If the sample is selected: `acc[k*PARALLEL+j] = (acc + entry_j) mod q`. The mod is truncation to `QBITS` bits; upper bits are zero.
  - Counters: k wraps at `CHUNKS` and then n increments.
  - The beat with n = `BIG_N-1` and k = `CHUNKS-1` moves the state to ENCODE.
  - ENCODE (exactly one cycle): `acc[0] = (acc[0] + m*DELTA) mod q`. Then `row = 0` and the state moves to OUTPUT.
  - OUTPUT: `out_valid = 1` and `ciphertext_entry = acc` chunk `row`. Each handshake increments `row`.
  - The handshake on the last chunk pulses `done` and returns the state to IDLE.
- Input entries must be < q; their upper bits are ignored through truncation.
- `start` outside IDLE is ignored and does not re-latch `plaintext`.
- `in_valid` outside ACCUM is ignored.
- A `subset_bit` change in the middle of a sample has no effect.
- Elaboration check: `$error` if p or q is not a power of two, if `PARALLEL` does not divide `DIMENSION+1`, or if `CIPHERTEXT_WIDTH < QBITS`.

## Timing
- Reset values: `in_ready` 0, `out_valid` 0, `ciphertext_entry` 0, `row` 0, `busy` 0, `done` 0; state IDLE; accumulators and counters 0.
- Asserting `rst_n` low in the middle of an operation aborts it immediately. No partial ciphertext is emitted afterwards.
- `in_ready` and `out_valid` are registered state decodes and depend on no combinational input.
- Latency: a `start` accepted at cycle 0 gives `in_ready` high at cycle 1. With no input stalls, the last beat is at cycle `BIG_N*CHUNKS`, ENCODE at +1, and the first `out_valid` at +2.
- Output with `out_ready` held high: one chunk per cycle, and `done` arrives in the cycle after the last handshake.
- While `out_valid && !out_ready`, `ciphertext_entry` and `row` hold stable.
- Input gaps (`in_valid` low) stall accumulation without losing state.

## Structure
- `lwe_pkg` holds the default parameter constants and the `clog2`-based helper for `CHUNKS`, `QBITS` and `DELTA`, shared with `decrypt`.
- One sub-module: `mod_add_vec`, a `PARALLEL`-wide modular adder with a per-lane enable, used for both accumulation and ENCODE.

## Test plan
All scenarios use default parameters; entries are listed as index 0..3.
1. All `subset_bit` = 0, m = 5: ciphertext = (80, 0, 0, 0); `done` is high for exactly one cycle.
2. Only sample 0 selected, entries (9, 3, 4, 8), m = 0: ciphertext = (9, 3, 4, 8) on rows 0 and 1.
3. Wrap-around: samples 0 and 1 selected, each with entries (1000, 1023, 512, 1), m = 63: ciphertext = (960, 1022, 0, 2).
4. Hold `out_ready` low for 5 cycles at OUTPUT: `out_valid` stays high and `row = 0` with its data unchanged; after release, both chunks appear on consecutive cycles.
5. Sample 2 selected with entries (1, 1, 1, 1) and `subset_bit` toggled on its chunk 1; `start` pulsed during ACCUM; random `in_valid` gaps; m = 0: ciphertext = (1, 1, 1, 1).
6. Assert `rst_n` low midway through ACCUM, then rerun scenario 2: all outputs are at reset values during reset and the ciphertext is (9, 3, 4, 8) with no stale contribution.
